// File: rtl/ofifo_drain_if.sv
// ofifo_drain_if: control, ofifo read and psum SRAM write signals of the drain controller
interface ofifo_drain_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 11
);
    logic                     start;
    logic [addr_w-1:0]        base_addr;
    logic [cnt_w-1:0]         num_rows;
    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     sram_cen;
    logic                     sram_wen;
    logic [addr_w-1:0]        sram_addr;
    logic [col*psum_bw-1:0]   sram_d;
    logic                     busy;
    logic                     done;
    modport master (
        input  start, base_addr, num_rows, ofifo_valid, ofifo_out,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );
    modport slave (
        output start, base_addr, num_rows, ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );
endinterface

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops num_rows rows from the ofifo, one read in flight, and writes them to consecutive SRAM addresses
module ofifo_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 11,
    parameter int rd_lat  = 2
) (
    input logic          clk,
    input logic          reset,
    ofifo_drain_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t            state, state_nx;
    logic [addr_w-1:0] wptr;
    logic [cnt_w-1:0]  target, rows_done;
    logic [2:0]        lat_cnt;
    logic              cap;
    assign bus.ofifo_rd = (state == ISSUE) && bus.ofifo_valid;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE;
    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.num_rows == '0) ? DONE : ISSUE;
            ISSUE:   if (bus.ofifo_valid) state_nx = WAIT;
            WAIT: begin
                cap      = lat_cnt == 3'd1;
                state_nx = !cap ? WAIT : (rows_done + cnt_w'(1) == target) ? DONE : ISSUE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wptr          <= '0;
            target        <= '0;
            rows_done     <= '0;
            lat_cnt       <= '0;
            bus.sram_cen  <= 1'b1;
            bus.sram_wen  <= 1'b1;
            bus.sram_addr <= '0;
            bus.sram_d    <= '0;
        end else begin
            state        <= state_nx;
            bus.sram_cen <= !cap;
            bus.sram_wen <= !cap;
            if (state == IDLE && bus.start) begin
                wptr      <= bus.base_addr;
                target    <= bus.num_rows;
                rows_done <= '0;
            end
            if (bus.ofifo_rd) lat_cnt <= 3'(rd_lat);
            else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;
            // capture on the last latency cycle; the strobe appears on the following cycle
            if (cap) begin
                bus.sram_d    <= bus.ofifo_out;
                bus.sram_addr <= wptr;
                wptr          <= wptr + addr_w'(1);
                rows_done     <= rows_done + cnt_w'(1);
            end
        end
    end
endmodule
